// File: rtl/traffic_light_pkg.sv
// Shared phase encodings and default timing for the traffic light controllers.
package traffic_light_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR_NS = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR_EW = 3'd5
  } phase_t;

  localparam int unsigned DEF_SECOND_CNT_VAL = 99;
  localparam int unsigned DEF_TIME_GREEN     = 15;
  localparam int unsigned DEF_TIME_YELLOW    = 3;
  localparam int unsigned DEF_TIME_ALL_RED   = 1;
  localparam int unsigned DEF_TIME_MIN_GREEN = 5;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      NS_G:    return NS_Y;
      NS_Y:    return AR_NS;
      AR_NS:   return EW_G;
      EW_G:    return EW_Y;
      EW_Y:    return AR_EW;
      default: return NS_G;
    endcase
  endfunction

endpackage

// File: rtl/second_tick_gen.sv
// One-second prescaler: pulses tick on the last enabled cycle of each second.
module second_tick_gen
  import traffic_light_pkg::*;
#(
  parameter int unsigned pSECOND_CNT_VAL = DEF_SECOND_CNT_VAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (pSECOND_CNT_VAL > 0) ? $clog2(pSECOND_CNT_VAL + 1) : 1;
  localparam logic [CW-1:0] TERM = CW'(pSECOND_CNT_VAL);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-way intersection phase sequencer with pedestrian green truncation.
//   state | meaning
//   NS_G  | north-south green, east-west red
//   NS_Y  | north-south yellow
//   AR_NS | all-red clearance after north-south
//   EW_G  | east-west green, north-south red
//   EW_Y  | east-west yellow
//   AR_EW | all-red clearance after east-west (reset state)
module traffic_phase_scheduler
  import traffic_light_pkg::*;
#(
  parameter int unsigned pSECOND_CNT_VAL   = DEF_SECOND_CNT_VAL,
  parameter int unsigned pTIME_GREEN_LIGHT  = DEF_TIME_GREEN,
  parameter int unsigned pTIME_YELLOW_LIGHT = DEF_TIME_YELLOW,
  parameter int unsigned pTIME_ALL_RED      = DEF_TIME_ALL_RED,
  parameter int unsigned pTIME_MIN_GREEN    = DEF_TIME_MIN_GREEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ped_req,
  output logic       ns_green,
  output logic       ns_yellow,
  output logic       ns_red,
  output logic       ew_green,
  output logic       ew_yellow,
  output logic       ew_red,
  output logic [6:0] sec_remain,
  output logic [2:0] phase,
  output logic       ped_ack
);

  localparam logic [6:0] T_GREEN  = 7'(pTIME_GREEN_LIGHT);
  localparam logic [6:0] T_YELLOW = 7'(pTIME_YELLOW_LIGHT);
  localparam logic [6:0] T_AR     = 7'(pTIME_ALL_RED);
  localparam logic [6:0] T_MIN    = 7'(pTIME_MIN_GREEN);

  phase_t     state, state_nxt;
  logic [6:0] sec_q, sec_nxt;
  logic       pend_q, pend_nxt;
  logic       ack_q, ack_nxt;
  logic       tick;
  logic       req_seen;
  logic       in_green;

  function automatic logic [6:0] dur(input phase_t p);
    case (p)
      NS_Y, EW_Y:   return T_YELLOW;
      AR_NS, AR_EW: return T_AR;
      default:      return T_GREEN;
    endcase
  endfunction

  second_tick_gen #(
    .pSECOND_CNT_VAL(pSECOND_CNT_VAL)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= AR_EW;
      sec_q  <= T_AR;
      pend_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      sec_q  <= sec_nxt;
      pend_q <= pend_nxt;
      ack_q  <= ack_nxt;
    end
  end

  // A request arriving this cycle counts immediately, so truncation lands one cycle after the pulse.
  always_comb begin
    state_nxt = state;
    sec_nxt   = sec_q;
    pend_nxt  = pend_q | ped_req;
    ack_nxt   = 1'b0;
    req_seen  = pend_q | ped_req;
    in_green  = (state == NS_G) || (state == EW_G);
    if (in_green && req_seen && (sec_q > T_MIN)) begin
      sec_nxt = T_MIN;
    end else if (tick) begin
      if (sec_q == 7'd1) begin
        state_nxt = next_phase(state);
        sec_nxt   = dur(state_nxt);
      end else begin
        sec_nxt = sec_q - 7'd1;
      end
    end
    if ((state_nxt != state) && ((state_nxt == AR_NS) || (state_nxt == AR_EW)) && pend_q) begin
      ack_nxt  = 1'b1;
      pend_nxt = ped_req;
    end
  end

  always_comb begin
    ns_green  = 1'b0;
    ns_yellow = 1'b0;
    ns_red    = 1'b1;
    ew_green  = 1'b0;
    ew_yellow = 1'b0;
    ew_red    = 1'b1;
    case (state)
      NS_G:    begin ns_green  = 1'b1; ns_red = 1'b0; end
      NS_Y:    begin ns_yellow = 1'b1; ns_red = 1'b0; end
      EW_G:    begin ew_green  = 1'b1; ew_red = 1'b0; end
      EW_Y:    begin ew_yellow = 1'b1; ew_red = 1'b0; end
      default: ;
    endcase
  end

  assign phase      = state;
  assign sec_remain = sec_q;
  assign ped_ack    = ack_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: timing table, corner sequences, random run vs model.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ped_req = 1'b0;
  logic       ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red;
  logic [6:0] sec_remain;
  logic [2:0] phase;
  logic       ped_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_phase_scheduler #(
    .pSECOND_CNT_VAL(9)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .ped_req   (ped_req),
    .ns_green  (ns_green),
    .ns_yellow (ns_yellow),
    .ns_red    (ns_red),
    .ew_green  (ew_green),
    .ew_yellow (ew_yellow),
    .ew_red    (ew_red),
    .sec_remain(sec_remain),
    .phase     (phase),
    .ped_ack   (ped_ack)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase index 0..5 cycling, seconds counted down per tick.
  int dur_s[6] = '{15, 3, 1, 15, 3, 1};
  int m_ph = 5, m_sec = 1, m_pre = 0;
  bit m_pend = 1'b0, m_ack = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 5; m_sec = 1; m_pre = 0; m_pend = 1'b0; m_ack = 1'b0;
    end else begin
      bit tk, trunc;
      tk = en && (m_pre == 9);
      if (en) m_pre = tk ? 0 : m_pre + 1;
      trunc = (m_ph % 3 == 0) && (m_pend || ped_req) && (m_sec > 5);
      m_ack = 1'b0;
      if (trunc) begin
        m_sec = 5;
        m_pend = 1'b1;
      end else if (tk && m_sec == 1) begin
        m_ph = (m_ph + 1) % 6;
        m_sec = dur_s[m_ph];
        if ((m_ph % 3 == 2) && m_pend) begin
          m_ack = 1'b1;
          m_pend = ped_req;
        end else begin
          m_pend = m_pend | ped_req;
        end
      end else begin
        if (tk) m_sec = m_sec - 1;
        m_pend = m_pend | ped_req;
      end
    end
  end

  function automatic logic [5:0] lamps_of(input int ph);
    return {ph == 0, ph == 1, ph > 1, ph == 3, ph == 4, !(ph == 3 || ph == 4)};
  endfunction

  always @(negedge clk) begin
    logic [16:0] act, exp;
    exp = {3'(m_ph), 7'(m_sec), m_ack, lamps_of(m_ph)};
    act = {phase, sec_remain, ped_ack, ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red};
    chk("model_cycle", int'(act), int'(exp));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_phase(input int ph, input int budget, output int n);
    n = 0;
    while (int'(phase) != ph && n < budget) begin
      step(1);
      n++;
    end
  endtask

  typedef struct {
    logic en;
    logic req;
    int   ncyc;
    int   ph;
    int   sec;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n;
    vecs[0]  = '{1'b1, 1'b0, 9,   5, 1};
    vecs[1]  = '{1'b1, 1'b0, 1,   0, 15};
    vecs[2]  = '{1'b1, 1'b0, 9,   0, 15};
    vecs[3]  = '{1'b1, 1'b0, 1,   0, 14};
    vecs[4]  = '{1'b1, 1'b0, 139, 0, 1};
    vecs[5]  = '{1'b1, 1'b0, 1,   1, 3};
    vecs[6]  = '{1'b1, 1'b0, 30,  2, 1};
    vecs[7]  = '{1'b1, 1'b0, 10,  3, 15};
    vecs[8]  = '{1'b0, 1'b0, 37,  3, 15};
    vecs[9]  = '{1'b1, 1'b0, 150, 4, 3};
    vecs[10] = '{1'b1, 1'b0, 30,  5, 1};
    vecs[11] = '{1'b1, 1'b0, 10,  0, 15};

    #12;
    chk("reset_phase", int'(phase), 5);
    chk("reset_sec", int'(sec_remain), 1);
    chk("reset_reds", int'({ns_red, ew_red}), 3);
    chk("reset_ack", int'(ped_ack), 0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      en = vecs[i].en;
      ped_req = vecs[i].req;
      step(vecs[i].ncyc);
      chk($sformatf("vec%0d_phase", i), int'(phase), vecs[i].ph);
      chk($sformatf("vec%0d_sec", i), int'(sec_remain), vecs[i].sec);
    end
    en = 1'b1;

    // Pedestrian pulse at 12 s left truncates NS green to 5 s.
    step(30);
    chk("trunc_pre_sec", int'(sec_remain), 12);
    ped_req = 1'b1; step(1); ped_req = 1'b0;
    chk("trunc_sec", int'(sec_remain), 5);
    wait_phase(1, 100, n);
    chk("trunc_len", n, 49);
    wait_phase(2, 100, n);
    chk("ns_y_len", n, 30);
    chk("ack_ar_ns", int'(ped_ack), 1);
    step(1);
    chk("ack_ar_ns_off", int'(ped_ack), 0);

    // Request below min green leaves timing alone.
    wait_phase(3, 100, n);
    chk("ew_g_entry", n, 9);
    step(110);
    chk("late_pre_sec", int'(sec_remain), 4);
    ped_req = 1'b1; step(1); ped_req = 1'b0;
    chk("late_sec", int'(sec_remain), 4);
    wait_phase(4, 100, n);
    chk("late_len", n, 39);
    wait_phase(5, 100, n);
    chk("ew_y_len", n, 30);
    chk("ack_ar_ew", int'(ped_ack), 1);

    // Reset in NS yellow.
    wait_phase(0, 100, n);
    chk("ns_g_entry", n, 10);
    wait_phase(1, 300, n);
    chk("ns_g_len", n, 150);
    step(12);
    rst_n = 1'b0;
    #1;
    chk("rst_phase", int'(phase), 5);
    chk("rst_sec", int'(sec_remain), 1);
    chk("rst_lamps", int'({ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red}), 9);
    chk("rst_ack", int'(ped_ack), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_phase(0, 100, n);
    chk("rst_release_len", n, 10);
    chk("rst_release_sec", int'(sec_remain), 15);

    // Request held across AR_NS entry stays pending and truncates EW green.
    wait_phase(1, 300, n);
    chk("ns_g_len2", n, 150);
    ped_req = 1'b1;
    wait_phase(2, 100, n);
    chk("hold_ns_y_len", n, 30);
    chk("hold_ack", int'(ped_ack), 1);
    step(1);
    ped_req = 1'b0;
    chk("hold_ack_off", int'(ped_ack), 0);
    wait_phase(3, 100, n);
    chk("hold_ar_len", n, 9);
    chk("hold_ew_sec", int'(sec_remain), 15);
    step(1);
    chk("hold_ew_trunc", int'(sec_remain), 5);
    wait_phase(4, 100, n);
    chk("hold_ew_len", n, 49);

    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      ped_req = ($urandom_range(0, 29) == 0);
      if (i == 2000) rst_n = 1'b0;
      if (i == 2003) rst_n = 1'b1;
      step(1);
    end
    ped_req = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
